// File: rtl/jtag_scan_sequencer.sv
// Purpose: turns RESET / SCAN_IR / SCAN_DR / IDLE commands into registered TMS/TDI streams for a JTAG TAP and captures TDO.
// Latency: first TMS/TDI pair the cycle after acceptance; a scan of N bits completes in N+6 (IR) or N+5 (DR) cycles plus a one-cycle DONE.
// Backpressure: o_cmd_ready is high only in IDLE and DONE; a command offered while busy is ignored until o_cmd_ready returns.
module jtag_scan_sequencer #(
    parameter int MAX_LEN = 32
) (
    input  logic               i_tck,
    input  logic               i_trst,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [1:0]         i_cmd_op,
    input  logic [5:0]         i_cmd_len,
    input  logic [MAX_LEN-1:0] i_cmd_data,
    output logic               o_tms,
    output logic               o_tdi,
    input  logic               i_tdo,
    output logic               o_rsp_valid,
    output logic [MAX_LEN-1:0] o_rsp_data,
    output logic               o_err,
    output logic               o_busy
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_PRE, S_SHIFT, S_POST, S_WAIT, S_DONE
    } state_t;

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_IR    = 2'b01;
    localparam logic [1:0] OP_DR    = 2'b10;
    localparam logic [1:0] OP_IDLE  = 2'b11;
    localparam logic [6:0] LP_MAX_LEN = 7'(MAX_LEN);

    state_t             r_state;
    logic [5:0]         r_cnt;
    logic [1:0]         r_op;
    logic [5:0]         r_len;
    logic [MAX_LEN-1:0] r_data;
    logic [MAX_LEN-1:0] r_cap;
    logic [MAX_LEN-1:0] r_bit;
    logic               r_tms;
    logic               r_tdi;
    logic               r_cmd_ready;
    logic               r_rsp_valid;
    logic [MAX_LEN-1:0] r_rsp_data;
    logic               r_err;

    logic               w_accept;
    logic               w_len_bad;
    logic               w_shift_last;
    logic               w_shift_next_last;
    logic [5:0]         w_pre_last;
    logic [5:0]         w_pre_next;
    logic               w_pre_tms;

    assign w_accept          = i_cmd_valid & r_cmd_ready;
    assign w_len_bad         = (i_cmd_len == 6'd0) || ({1'b0, i_cmd_len} > LP_MAX_LEN);
    assign w_shift_last      = (r_cnt == r_len - 6'd1);
    assign w_shift_next_last = (r_cnt + 6'd2 == r_len);

    assign o_cmd_ready = r_cmd_ready;
    assign o_busy      = ~r_cmd_ready;
    assign o_tms       = r_tms;
    assign o_tdi       = r_tdi;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_err       = r_err;

    // Preamble shape per operation: length and TMS value of the next preamble cycle.
    always_comb begin
        w_pre_next = r_cnt + 6'd1;
        w_pre_last = 6'd5;
        w_pre_tms  = 1'b0;
        case (r_op)
            OP_IR:   begin w_pre_last = 6'd3; w_pre_tms = (w_pre_next < 6'd2); end
            OP_DR:   begin w_pre_last = 6'd2; w_pre_tms = 1'b0; end
            default: begin w_pre_last = 6'd5; w_pre_tms = (w_pre_next < 6'd5); end
        endcase
    end

    // Sequencer FSM: every output is registered, so each state sets up the pair for the following cycle.
    always_ff @(posedge i_tck or posedge i_trst) begin
        if (i_trst) begin
            r_state     <= S_INIT;
            r_cnt       <= 6'd0;
            r_op        <= OP_RESET;
            r_len       <= 6'd0;
            r_data      <= '0;
            r_cap       <= '0;
            r_bit       <= '0;
            r_tms       <= 1'b1;
            r_tdi       <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_INIT: begin
                    // Five TMS=1 cycles reach Test-Logic-Reset, one TMS=0 parks in Run-Test/Idle.
                    if (r_cnt == 6'd5) begin
                        r_state     <= S_IDLE;
                        r_cnt       <= 6'd0;
                        r_tms       <= 1'b0;
                        r_cmd_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                        r_tms <= (r_cnt != 6'd4);
                    end
                end
                S_IDLE, S_DONE: begin
                    r_state     <= S_IDLE;
                    r_tms       <= 1'b0;
                    r_tdi       <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    if (w_accept) begin
                        r_op   <= i_cmd_op;
                        r_len  <= i_cmd_len;
                        r_data <= i_cmd_data;
                        r_cap  <= '0;
                        r_bit  <= {{(MAX_LEN-1){1'b0}}, 1'b1};
                        r_cnt  <= 6'd0;
                        case (i_cmd_op)
                            OP_RESET: begin
                                r_state     <= S_PRE;
                                r_tms       <= 1'b1;
                                r_cmd_ready <= 1'b0;
                            end
                            OP_IDLE: begin
                                if (i_cmd_len == 6'd0) begin
                                    r_state     <= S_DONE;
                                    r_rsp_valid <= 1'b1;
                                    r_rsp_data  <= '0;
                                    r_err       <= 1'b0;
                                end else begin
                                    r_state     <= S_WAIT;
                                    r_cmd_ready <= 1'b0;
                                end
                            end
                            default: begin
                                // Zero-length or oversize scans are refused without touching the TAP.
                                if (w_len_bad) begin
                                    r_state     <= S_DONE;
                                    r_rsp_valid <= 1'b1;
                                    r_rsp_data  <= '0;
                                    r_err       <= 1'b1;
                                end else begin
                                    r_state     <= S_PRE;
                                    r_tms       <= 1'b1;
                                    r_cmd_ready <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
                S_PRE: begin
                    if (r_cnt == w_pre_last) begin
                        if (r_op == OP_RESET) begin
                            r_state     <= S_DONE;
                            r_tms       <= 1'b0;
                            r_cmd_ready <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= '0;
                            r_err       <= 1'b0;
                        end else begin
                            r_state <= S_SHIFT;
                            r_cnt   <= 6'd0;
                            r_tms   <= (r_len == 6'd1);
                            r_tdi   <= r_data[0];
                            r_data  <= r_data >> 1;
                        end
                    end else begin
                        r_cnt <= w_pre_next;
                        r_tms <= w_pre_tms;
                    end
                end
                S_SHIFT: begin
                    // TDO for the current bit is valid on the edge that ends its cycle.
                    r_cap <= r_cap | ({MAX_LEN{i_tdo}} & r_bit);
                    r_bit <= r_bit << 1;
                    if (w_shift_last) begin
                        r_state <= S_POST;
                        r_cnt   <= 6'd0;
                        r_tms   <= 1'b1;
                        r_tdi   <= 1'b0;
                    end else begin
                        r_cnt  <= r_cnt + 6'd1;
                        r_tms  <= w_shift_next_last;
                        r_tdi  <= r_data[0];
                        r_data <= r_data >> 1;
                    end
                end
                S_POST: begin
                    if (r_cnt == 6'd0) begin
                        r_cnt <= 6'd1;
                        r_tms <= 1'b0;
                    end else begin
                        r_state     <= S_DONE;
                        r_cmd_ready <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_cap;
                        r_err       <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == r_len - 6'd1) begin
                        r_state     <= S_DONE;
                        r_cmd_ready <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= '0;
                        r_err       <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Bench for jtag_scan_sequencer: tracks a TAP controller state machine driven by the DUT's TMS,
// serves TDO from the shift states, and checks each command against a queue-based reference model.
module tb_jtag_scan_sequencer;

    localparam int MAX_LEN = 32;

    logic        i_tck = 1'b0;
    logic        i_trst = 1'b1;
    logic        i_cmd_valid = 1'b0;
    logic [1:0]  i_cmd_op = 2'b00;
    logic [5:0]  i_cmd_len = 6'd0;
    logic [31:0] i_cmd_data = 32'd0;
    logic        i_tdo = 1'b0;
    logic        o_cmd_ready, o_tms, o_tdi, o_rsp_valid, o_err, o_busy;
    logic [31:0] o_rsp_data;

    jtag_scan_sequencer #(.MAX_LEN(MAX_LEN)) dut (
        .i_tck(i_tck), .i_trst(i_trst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_op(i_cmd_op), .i_cmd_len(i_cmd_len), .i_cmd_data(i_cmd_data),
        .o_tms(o_tms), .o_tdi(o_tdi), .i_tdo(i_tdo), .o_rsp_valid(o_rsp_valid),
        .o_rsp_data(o_rsp_data), .o_err(o_err), .o_busy(o_busy)
    );

    always #5 i_tck = ~i_tck;

    // ---------------- target TAP controller ----------------
    typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PDR, EX2DR, UPDR,
                      SELIR, CAPIR, SHIR, EX1IR, PIR, EX2IR, UPIR} tap_t;

    function automatic tap_t tap_next(input tap_t s, input logic tms);
        case (s)
            TLR:   return tms ? TLR   : RTI;
            RTI:   return tms ? SELDR : RTI;
            SELDR: return tms ? SELIR : CAPDR;
            CAPDR: return tms ? EX1DR : SHDR;
            SHDR:  return tms ? EX1DR : SHDR;
            EX1DR: return tms ? UPDR  : PDR;
            PDR:   return tms ? EX2DR : PDR;
            EX2DR: return tms ? UPDR  : SHDR;
            UPDR:  return tms ? SELDR : RTI;
            SELIR: return tms ? TLR   : CAPIR;
            CAPIR: return tms ? EX1IR : SHIR;
            SHIR:  return tms ? EX1IR : SHIR;
            EX1IR: return tms ? UPIR  : PIR;
            PIR:   return tms ? EX2IR : PIR;
            EX2IR: return tms ? UPIR  : SHIR;
            default: return tms ? SELDR : RTI;
        endcase
    endfunction

    tap_t        tap_st;
    tap_t        tap_nx;
    int          sh_idx = 0;
    int          upd_ir = 0;
    int          upd_dr = 0;
    int          rsp_cnt = 0;
    logic [31:0] tdo_pat = 32'd0;

    always @(posedge i_tck or posedge i_trst) begin
        if (i_trst) begin
            tap_st <= SHDR;
            sh_idx <= 0;
        end else begin
            tap_nx = tap_next(tap_st, o_tms);
            tap_st <= tap_nx;
            sh_idx <= (tap_st == SHDR || tap_st == SHIR) ? sh_idx + 1 : 0;
            if (tap_nx == UPIR) upd_ir <= upd_ir + 1;
            if (tap_nx == UPDR) upd_dr <= upd_dr + 1;
        end
    end

    always @(posedge i_tck) if (o_rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;

    always @(negedge i_tck)
        i_tdo = ((tap_st == SHDR || tap_st == SHIR) && sh_idx < 32) ? tdo_pat[sh_idx[4:0]] : 1'b0;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: build the TMS/TDI cycle stream from the TAP walk each command implies.
    function automatic void model(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                                  input logic [31:0] tdo, output logic [63:0] tms_v, output logic [63:0] tdi_v,
                                  output int ncyc, output logic err, output logic [31:0] rsp,
                                  output int n_uir, output int n_udr);
        bit qt[$];
        bit qd[$];
        int n;
        n = int'(len);
        tms_v = '0; tdi_v = '0; err = 1'b0; rsp = '0; n_uir = 0; n_udr = 0;
        case (op)
            2'b00: for (int i = 0; i < 6; i++) begin qt.push_back(i < 5); qd.push_back(1'b0); end
            2'b11: for (int i = 0; i < n; i++) begin qt.push_back(1'b0); qd.push_back(1'b0); end
            default: begin
                if (n == 0 || n > MAX_LEN) err = 1'b1;
                else begin
                    qt.push_back(1'b1); qd.push_back(1'b0);
                    if (op == 2'b01) begin qt.push_back(1'b1); qd.push_back(1'b0); end
                    qt.push_back(1'b0); qd.push_back(1'b0);
                    qt.push_back(1'b0); qd.push_back(1'b0);
                    for (int k = 0; k < n; k++) begin
                        qt.push_back(k == n - 1);
                        qd.push_back(data[k[4:0]]);
                        rsp[k[4:0]] = tdo[k[4:0]];
                    end
                    qt.push_back(1'b1); qd.push_back(1'b0);
                    qt.push_back(1'b0); qd.push_back(1'b0);
                    if (op == 2'b01) n_uir = 1; else n_udr = 1;
                end
            end
        endcase
        ncyc = qt.size();
        for (int i = 0; i < ncyc; i++) begin
            tms_v[i[5:0]] = qt[i];
            tdi_v[i[5:0]] = qd[i];
        end
    endfunction

    logic [63:0] g_tms, g_tdi;
    int          g_n;
    logic        g_err, g_done;
    logic [31:0] g_rsp;

    task automatic wait_ready(input string tag);
        int guard;
        guard = 0;
        @(negedge i_tck);
        while (o_cmd_ready !== 1'b1 && guard < 100) begin
            @(negedge i_tck);
            guard++;
        end
        chk({tag, " ready"}, 64'(o_cmd_ready), 64'd1);
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                           input logic [31:0] tdo, input string tag);
        logic [63:0] e_tms, e_tdi;
        int          e_n, e_uir, e_udr, uir0, udr0;
        logic        e_err;
        logic [31:0] e_rsp;
        model(op, len, data, tdo, e_tms, e_tdi, e_n, e_err, e_rsp, e_uir, e_udr);
        tdo_pat = tdo;
        g_tms = '0; g_tdi = '0; g_n = 0; g_done = 1'b0; g_err = 1'b0; g_rsp = '0;
        wait_ready(tag);
        uir0 = upd_ir; udr0 = upd_dr;
        i_cmd_valid = 1'b1; i_cmd_op = op; i_cmd_len = len; i_cmd_data = data;
        @(posedge i_tck);
        #1 i_cmd_valid = 1'b0;
        for (int c = 0; c < 100 && !g_done; c++) begin
            @(negedge i_tck);
            if (o_rsp_valid === 1'b1) begin
                g_done = 1'b1; g_err = o_err; g_rsp = o_rsp_data;
                chk({tag, " done_tms_ready_busy_rti"}, 64'({o_tms, o_cmd_ready, o_busy, tap_st == RTI}), 64'b0101);
            end else begin
                g_tms[g_n[5:0]] = o_tms;
                g_tdi[g_n[5:0]] = o_tdi;
                g_n++;
            end
        end
        chk({tag, " rsp_valid_seen"}, 64'(g_done), 64'd1);
        chk({tag, " cycles"}, 64'(g_n), 64'(e_n));
        chk({tag, " tms_seq"}, g_tms, e_tms);
        chk({tag, " tdi_seq"}, g_tdi, e_tdi);
        chk({tag, " err"}, 64'(g_err), 64'(e_err));
        chk({tag, " rsp_data"}, 64'(g_rsp), 64'(e_rsp));
        chk({tag, " update_ir_dr"}, {32'(upd_ir - uir0), 32'(upd_dr - udr0)}, {32'(e_uir), 32'(e_udr)});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " rst_tms_tdi_rdy_busy_vld_err"},
            64'({o_tms, o_tdi, o_cmd_ready, o_busy, o_rsp_valid, o_err}), 64'b100100);
        chk({tag, " rst_rsp_data"}, 64'(o_rsp_data), 64'd0);
    endtask

    task automatic do_release(input string tag);
        logic [6:0] tv, rv;
        int r0;
        r0 = rsp_cnt;
        @(negedge i_tck);
        i_trst = 1'b0;
        #1;
        tv[0] = o_tms; rv[0] = o_cmd_ready;
        for (int c = 1; c < 7; c++) begin
            @(negedge i_tck);
            tv[c[2:0]] = o_tms; rv[c[2:0]] = o_cmd_ready;
        end
        chk({tag, " init_tms_seq"}, 64'(tv), 64'h1F);
        chk({tag, " init_ready_seq"}, 64'(rv), 64'h40);
        chk({tag, " init_tap_rti"}, 64'(tap_st == RTI), 64'd1);
        chk({tag, " init_no_rsp"}, 64'(rsp_cnt - r0), 64'd0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [5:0]  len;
        logic [31:0] data;
        logic [31:0] tdo;
        int          exp_n;
        logic        exp_err;
        logic [31:0] exp_rsp;
    } vec_t;

    vec_t vt[11];

    initial begin
        logic [10:0] tv, vv, rv;
        logic        tdi_s, err_s;
        logic [31:0] rsp_s;
        int          r0;
        logic [1:0]  rop;
        logic [5:0]  rlen;

        vt[0]  = '{2'b01, 6'd4,  32'h0000000A, 32'h00000005, 10, 1'b0, 32'h00000005};
        vt[1]  = '{2'b10, 6'd32, 32'hDEADBEEF, 32'h12345678, 37, 1'b0, 32'h12345678};
        vt[2]  = '{2'b10, 6'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 0,  1'b1, 32'h00000000};
        vt[3]  = '{2'b10, 6'd40, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,  1'b1, 32'h00000000};
        vt[4]  = '{2'b11, 6'd3,  32'h00000000, 32'h00000000, 3,  1'b0, 32'h00000000};
        vt[5]  = '{2'b11, 6'd0,  32'h00000000, 32'h00000000, 0,  1'b0, 32'h00000000};
        vt[6]  = '{2'b00, 6'd0,  32'h00000000, 32'h00000000, 6,  1'b0, 32'h00000000};
        vt[7]  = '{2'b10, 6'd1,  32'h00000001, 32'h00000001, 6,  1'b0, 32'h00000001};
        vt[8]  = '{2'b01, 6'd33, 32'h00000000, 32'h00000000, 0,  1'b1, 32'h00000000};
        vt[9]  = '{2'b01, 6'd32, 32'hFFFFFFFF, 32'h80000001, 38, 1'b0, 32'h80000001};
        vt[10] = '{2'b10, 6'd5,  32'h00000015, 32'hFFFFFFFF, 10, 1'b0, 32'h0000001F};

        // power-on reset and INIT sequence
        repeat (3) @(negedge i_tck);
        chk_reset("por");
        do_release("por");

        // SCAN_IR LEN=4 DATA=0xA with explicit cycle-by-cycle expectations
        run_cmd(2'b01, 6'd4, 32'hA, 32'h5, "ir4");
        chk("ir4 tms_explicit", g_tms, 64'h183);
        chk("ir4 tdi_explicit", g_tdi, 64'hA0);

        for (int i = 0; i < 11; i++) begin
            run_cmd(vt[i].op, vt[i].len, vt[i].data, vt[i].tdo, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl_cycles", i), 64'(g_n), 64'(vt[i].exp_n));
            chk($sformatf("vec%0d tbl_err", i), 64'(g_err), 64'(vt[i].exp_err));
            chk($sformatf("vec%0d tbl_rsp", i), 64'(g_rsp), 64'(vt[i].exp_rsp));
        end
        repeat (4) @(negedge i_tck);
        chk("rsp_data_hold", 64'(o_rsp_data), 64'h1F);

        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 3));
            if (rop != 2'b00 && rop != 2'b11 && $urandom_range(0, 3) != 0) rlen = 6'($urandom_range(1, 32));
            else rlen = 6'($urandom_range(0, 63));
            run_cmd(rop, rlen, $urandom, $urandom, $sformatf("rand%0d", i));
        end

        // back-to-back: IDLE 3 then SCAN_DR 1 accepted in DONE; CMD_VALID toggled while busy
        tdo_pat = 32'h1;
        wait_ready("b2b");
        i_cmd_valid = 1'b1; i_cmd_op = 2'b11; i_cmd_len = 6'd3; i_cmd_data = 32'd0;
        tdi_s = 1'b0; err_s = 1'b1; rsp_s = '0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge i_tck);
            tv[i-1] = o_tms; vv[i-1] = o_rsp_valid; rv[i-1] = o_cmd_ready;
            if (i == 8) tdi_s = o_tdi;
            if (i == 11) begin rsp_s = o_rsp_data; err_s = o_err; end
            case (i)
                1: begin i_cmd_op = 2'b10; i_cmd_len = 6'd1; i_cmd_data = 32'h1; i_cmd_valid = 1'b0; end
                2: i_cmd_valid = 1'b1;
                3: i_cmd_valid = 1'b0;
                4: i_cmd_valid = 1'b1;
                5: i_cmd_valid = 1'b0;
                default: ;
            endcase
        end
        chk("b2b tms_seq", 64'(tv), 64'h190);
        chk("b2b rsp_valid_seq", 64'(vv), 64'h408);
        chk("b2b ready_seq", 64'(rv), 64'h408);
        chk("b2b shift_tdi", 64'(tdi_s), 64'd1);
        chk("b2b rsp_err", {31'd0, err_s, rsp_s}, 64'h1);

        // TRST during the SHIFT phase of SCAN_DR LEN=16
        tdo_pat = $urandom;
        wait_ready("abort");
        i_cmd_valid = 1'b1; i_cmd_op = 2'b10; i_cmd_len = 6'd16; i_cmd_data = $urandom;
        @(posedge i_tck);
        #1 i_cmd_valid = 1'b0;
        repeat (5) @(negedge i_tck);
        chk("abort in_shift", 64'(tap_st == SHDR), 64'd1);
        r0 = rsp_cnt;
        #1 i_trst = 1'b1;
        #1 chk_reset("abort_now");
        repeat (2) @(negedge i_tck);
        chk_reset("abort_hold");
        do_release("abort");
        repeat (20) @(negedge i_tck);
        chk("abort no_rsp", 64'(rsp_cnt - r0), 64'd0);
        run_cmd(2'b01, 6'd8, 32'h5A, 32'hC3, "post_abort");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required summary before 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/jtag_scan_sequencer.md
JTAG_SCAN_SEQUENCER -- requirements
Module: jtag_scan_sequencer

Interface
REQ-001 Parameter MAX_LEN, default 32, is the maximum scan length in bits and the width of CMD_DATA and RSP_DATA.
REQ-002 TCK  input  1  single clock; all state updates on posedge.
REQ-003 TRST  input  1  reset, asynchronous, active-high.
REQ-004 CMD_VALID  input  1  command offered.
REQ-005 CMD_READY  output  1  sequencer can accept a command.
REQ-006 CMD_OP  input  2  operation: 00 RESET, 01 SCAN_IR, 10 SCAN_DR, 11 IDLE.
REQ-007 CMD_LEN  input  6  bit count for scans, or cycle count for IDLE.
REQ-008 CMD_DATA  input  MAX_LEN  TDI data, shifted LSB first.
REQ-009 TMS  output  1  registered TMS to the target TAP.
REQ-010 TDI  output  1  registered TDI to the target TAP.
REQ-011 TDO  input  1  target TDO.
REQ-012 RSP_VALID  output  1  one-cycle completion pulse.
REQ-013 RSP_DATA  output  MAX_LEN  captured TDO bits; held until the next RSP_VALID.
REQ-014 ERR  output  1  valid with RSP_VALID; 1 means the command was rejected.
REQ-015 BUSY  output  1  high whenever CMD_READY is low.

Function
REQ-016 A command is accepted on the posedge where CMD_VALID and CMD_READY are both 1; CMD_READY drops the following cycle.
- The block latches CMD_OP, CMD_LEN and CMD_DATA on acceptance.
- CMD_VALID while CMD_READY=0 has no effect.
REQ-017 FSM states: INIT, IDLE, PRE, SHIFT, POST, WAIT, DONE.
REQ-018 The block emits one TMS/TDI pair per TCK cycle, starting the cycle after acceptance, and holds TMS=0 and TDI=0 in IDLE and DONE.
REQ-019 SCAN_IR, starting from Run-Test/Idle, SHALL drive:
- PRE: TMS 1,1,0,0.
- SHIFT: N cycles; TMS=0 except 1 on the last bit; TDI=CMD_DATA[k] in shift cycle k.
- POST: TMS 1,0.
- Total N+6 cycles.
REQ-020 SCAN_DR SHALL be identical to SCAN_IR except PRE is TMS 1,0,0, giving N+5 cycles total.
REQ-021 In shift cycle k (0-based), the block samples TDO on the posedge that ends the cycle into RSP_DATA[k]; RSP_DATA bits at N and above become 0.
REQ-022 When N=1, the single shift cycle has TMS=1.
REQ-023 RESET SHALL drive TMS=1 for 5 cycles, then TMS=0 for 1 cycle, leaving the TAP in Run-Test/Idle.
REQ-024 IDLE SHALL drive TMS=0 for CMD_LEN cycles (WAIT state); CMD_LEN=0 goes directly to DONE.
REQ-025 DONE lasts one cycle.
- RSP_VALID=1 and CMD_READY=1 in that cycle.
- A command accepted in DONE starts on the next cycle, so back-to-back commands are separated by exactly one TMS=0 cycle.
REQ-026 A SCAN with CMD_LEN=0 or CMD_LEN>MAX_LEN goes straight to DONE without toggling TMS, with ERR=1 and RSP_DATA=0.
REQ-027 RESET and IDLE return RSP_DATA=0 and ERR=0.
REQ-028 A valid SCAN returns ERR=0.
REQ-029 A 6-bit counter SHALL track PRE, POST, SHIFT and WAIT progress, with no wrap permitted within a command.

Reset
REQ-030 While TRST=1, the block is in INIT with the counter cleared and outputs:
- TMS=1, TDI=0.
- CMD_READY=0, BUSY=1.
- RSP_VALID=0, RSP_DATA=0, ERR=0.
REQ-031 After TRST deasserts, INIT SHALL run the RESET sequence (TMS=1 for 5 posedges, then TMS=0 for 1), then enter IDLE with CMD_READY=1, and SHALL NOT pulse RSP_VALID.
REQ-032 TRST asserted mid-command SHALL abort it immediately: no RSP_VALID, latched command discarded, INIT restarted.

Verification
REQ-033 The bench SHALL instantiate tapController as the target and track its state each cycle.
- Release TRST -> TMS 1,1,1,1,1,0 on consecutive cycles.
- CMD_READY=1 on the 7th cycle.
- Target in Run-Test/Idle.
REQ-034 SCAN_IR, LEN=4, DATA=0xA:
- TMS 1,1,0,0,0,0,0,1,1,0.
- TDI 0,1,0,1 during shift.
- RSP_VALID on cycle 11.
- Target UPDATEIR pulses once.
REQ-035 SCAN_DR, LEN=32, with a TDO model returning 0x12345678 LSB first -> RSP_DATA=0x12345678, ERR=0, 37 TMS cycles.
REQ-036 SCAN_DR with LEN=0 and separately LEN=40 -> RSP_VALID the cycle after acceptance, ERR=1, TMS constant 0.
REQ-037 TRST pulsed during the SHIFT phase of SCAN_DR LEN=16 -> outputs return to reset values immediately, INIT sequence reruns, and no RSP_VALID for the aborted command.
REQ-038 Back-to-back commands:
- IDLE LEN=3 followed by SCAN_DR LEN=1 held valid -> second command accepted in the DONE cycle.
- Single-bit scan drives TMS=1 in its only shift cycle.
- CMD_VALID toggled while BUSY=1 is ignored.
